demux_stream: RTL and testbench

- Parametrised, registered successor to the 1-bit 2-way demultiplexer.
- Routes one WIDTH-bit input stream to one of CHANNELS output streams, or to all of them in broadcast mode.
- Uses a valid/ready handshake on every side and a one-entry holding register per output channel.
- Sits between a single producer and multiple consumer blocks, for example per-unit command dispatch.

---
 rtl/demux_stream_if.sv | 30 +++
 rtl/demux_stream.sv | 88 ++++++++
 tb/tb_demux_stream.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_if.sv
// demux_stream_if: handshake bundle between a producer, the demux and its consumers.
// Ports: in* = producer side (valid/ready/data/select/broadcast), out* = per-channel consumer side, dropCount = status.
interface demux_stream_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int COUNT_W  = 8
);
   logic                      inValid;
   logic                      inReady;
   logic [WIDTH-1:0]          inData;
   logic [SEL_W-1:0]          inSelect;
   logic                      inBroadcast;
   logic [CHANNELS-1:0]       outValid;
   logic [CHANNELS-1:0]       outReady;
   logic [CHANNELS*WIDTH-1:0] outData;
   logic [COUNT_W-1:0]        dropCount;

   // master: the surrounding producer and consumers
   modport master (
      output inValid, inData, inSelect, inBroadcast, outReady,
      input  inReady, outValid, outData, dropCount
   );

   // slave: the demux itself
   modport slave (
      input  inValid, inData, inSelect, inBroadcast, outReady,
      output inReady, outValid, outData, dropCount
   );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: routes one valid/ready stream to one of CHANNELS outputs (or all, on broadcast),
// one holding register per channel. Ports: clk, reset (sync, active-high), bus (demux_stream_if.slave).
module demux_stream #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int COUNT_W  = 8
) (
   input logic           clk,
   input logic           reset,
   demux_stream_if.slave bus
);
   typedef enum logic {EMPTY, FULL} ch_state_e;

   ch_state_e           state_q [CHANNELS];
   ch_state_e           state_d [CHANNELS];
   logic [WIDTH-1:0]    data_q  [CHANNELS];
   logic [COUNT_W-1:0]  cnt_q, cnt_d;

   logic [CHANNELS-1:0] free;
   logic [CHANNELS-1:0] tgt;
   logic [CHANNELS-1:0] load;
   logic                in_range;
   logic                accept;
   logic                drop;

   // Routing decode; inReady never looks at inValid.
   always_comb begin
      free     = '0;
      tgt      = '0;
      in_range = int'(bus.inSelect) < CHANNELS;
      for (int i = 0; i < CHANNELS; i++) begin
         free[i] = (state_q[i] == EMPTY) || bus.outReady[i];
         tgt[i]  = bus.inBroadcast || (int'(bus.inSelect) == i);
      end
      if (bus.inBroadcast)
         bus.inReady = &free;
      else if (in_range)
         bus.inReady = |(tgt & free);
      else
         bus.inReady = 1'b1;
      accept = bus.inValid && bus.inReady;
      // tgt is empty for an out-of-range select, so nothing loads
      load   = accept ? tgt : '0;
      drop   = accept && !bus.inBroadcast && !in_range;
   end

   // Per-channel next state: load beats drain beats hold.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         if (load[i])
            state_d[i] = FULL;
         else if (state_q[i] == FULL && bus.outReady[i])
            state_d[i] = EMPTY;
      end
      cnt_d = cnt_q;
      if (drop && cnt_q != '1)
         cnt_d = cnt_q + COUNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= EMPTY;
            data_q[i]  <= '0;
         end
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            if (load[i])
               data_q[i] <= bus.inData;
         end
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      bus.outValid = '0;
      bus.outData  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         bus.outValid[i]                 = (state_q[i] == FULL);
         bus.outData[i*WIDTH +: WIDTH]   = data_q[i];
      end
      bus.dropCount = cnt_q;
   end
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed table, corner sequences and a randomised scoreboard run.
// Instances: 4-channel default demux and a 3-channel, 2-bit-counter demux for drop tests.
module tb_demux_stream;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   demux_stream_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .COUNT_W(8)) bus ();
   demux_stream_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .COUNT_W(2)) bus3 ();

   demux_stream #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .COUNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   demux_stream #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .COUNT_W(2)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [1:0] sel;
      logic       bc;
      logic [7:0] d;
      logic [3:0] ordy;
      logic       rdy;
      logic [3:0] ov;
      logic [31:0] od;
   } vec_t;

   vec_t tbl [16];
   logic [7:0] sb [4][$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.inValid     = 1'b0;
      bus.inData      = 8'h00;
      bus.inSelect    = 2'd0;
      bus.inBroadcast = 1'b0;
      bus.outReady    = 4'b0000;
      bus3.inValid     = 1'b0;
      bus3.inData      = 8'h00;
      bus3.inSelect    = 2'd0;
      bus3.inBroadcast = 1'b0;
      bus3.outReady    = 3'b000;
   endtask

   function automatic logic [31:0] vmask(input logic [3:0] ov);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++)
         if (ov[i]) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   initial begin
      logic [31:0] m;
      logic [3:0]  fr;
      logic        erdy;
      logic [3:0]  eov;
      logic [1:0]  edrop;
      checks   = 0;
      failures = 0;

      tbl[0]  = '{1'b1, 2'd2, 1'b0, 8'h3C, 4'b0000, 1'b1, 4'b0100, 32'h003C0000};
      tbl[1]  = '{1'b1, 2'd2, 1'b0, 8'h55, 4'b0000, 1'b0, 4'b0100, 32'h003C0000};
      tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'h55, 4'b0000, 1'b0, 4'b0100, 32'h003C0000};
      tbl[3]  = '{1'b0, 2'd2, 1'b0, 8'h55, 4'b0100, 1'b1, 4'b0000, 32'h00000000};
      tbl[4]  = '{1'b1, 2'd1, 1'b0, 8'h01, 4'b0010, 1'b1, 4'b0010, 32'h00000100};
      tbl[5]  = '{1'b1, 2'd1, 1'b0, 8'h02, 4'b0010, 1'b1, 4'b0010, 32'h00000200};
      tbl[6]  = '{1'b1, 2'd1, 1'b0, 8'h03, 4'b0010, 1'b1, 4'b0010, 32'h00000300};
      tbl[7]  = '{1'b0, 2'd1, 1'b0, 8'h00, 4'b0010, 1'b1, 4'b0000, 32'h00000000};
      tbl[8]  = '{1'b1, 2'd3, 1'b0, 8'h77, 4'b0000, 1'b1, 4'b1000, 32'h77000000};
      tbl[9]  = '{1'b1, 2'd0, 1'b1, 8'hFF, 4'b0000, 1'b0, 4'b1000, 32'h77000000};
      tbl[10] = '{1'b1, 2'd0, 1'b1, 8'hFF, 4'b1000, 1'b1, 4'b1111, 32'hFFFFFFFF};
      tbl[11] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00000000};
      tbl[12] = '{1'b1, 2'd0, 1'b0, 8'hAA, 4'b0000, 1'b1, 4'b0001, 32'h000000AA};
      tbl[13] = '{1'b1, 2'd1, 1'b0, 8'hBB, 4'b0000, 1'b1, 4'b0011, 32'h0000BBAA};
      tbl[14] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b0001, 1'b1, 4'b0010, 32'h0000BB00};
      tbl[15] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b0010, 1'b1, 4'b0000, 32'h00000000};

      // reset and idle
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ov", 64'(bus.outValid), 64'(4'b0000));
      chk("rst_od", 64'(bus.outData), 64'(32'h0));
      chk("rst_drop", 64'(bus.dropCount), 64'(8'd0));
      for (int s = 0; s < 4; s++) begin
         bus.inSelect = 2'(s);
         #1;
         chk("rst_rdy", 64'(bus.inReady), 64'(1'b1));
      end
      tick();

      // directed table
      for (int k = 0; k < 16; k++) begin
         bus.inValid     = tbl[k].v;
         bus.inSelect    = tbl[k].sel;
         bus.inBroadcast = tbl[k].bc;
         bus.inData      = tbl[k].d;
         bus.outReady    = tbl[k].ordy;
         #1;
         chk($sformatf("tbl%0d_rdy", k), 64'(bus.inReady), 64'(tbl[k].rdy));
         tick();
         m = vmask(tbl[k].ov);
         chk($sformatf("tbl%0d_ov", k), 64'(bus.outValid), 64'(tbl[k].ov));
         chk($sformatf("tbl%0d_od", k), 64'(bus.outData & m), 64'(tbl[k].od));
      end
      idle();
      tick();

      // reset while channel 2 holds A5
      bus.inValid  = 1'b1;
      bus.inSelect = 2'd2;
      bus.inData   = 8'hA5;
      tick();
      idle();
      chk("mid_full", 64'(bus.outValid), 64'(4'b0100));
      chk("mid_data", 64'(bus.outData[23:16]), 64'(8'hA5));
      reset = 1'b1;
      bus.outReady = 4'b0100;
      tick();
      reset = 1'b0;
      bus.outReady = 4'b0000;
      chk("mid_rst_ov", 64'(bus.outValid), 64'(4'b0000));
      chk("mid_rst_od", 64'(bus.outData), 64'(32'h0));

      // 3-channel block: fill ch0, then out-of-range drops
      bus3.inValid  = 1'b1;
      bus3.inSelect = 2'd0;
      bus3.inData   = 8'h11;
      tick();
      chk("c3_load", 64'(bus3.outValid), 64'(3'b001));
      bus3.inSelect = 2'd3;
      edrop = 2'd0;
      for (int k = 0; k < 5; k++) begin
         bus3.inData = 8'(8'h20 + k);
         #1;
         chk("c3_drop_rdy", 64'(bus3.inReady), 64'(1'b1));
         tick();
         if (edrop != 2'd3) edrop = edrop + 2'd1;
         chk("c3_drop_ov", 64'(bus3.outValid), 64'(3'b001));
         chk("c3_drop_cnt", 64'(bus3.dropCount), 64'(edrop));
      end
      chk("c3_sat", 64'(bus3.dropCount), 64'(2'd3));
      chk("c3_hold", 64'(bus3.outData[7:0]), 64'(8'h11));
      bus3.inBroadcast = 1'b1;
      #1;
      chk("c3_bc_stall", 64'(bus3.inReady), 64'(1'b0));
      bus3.outReady = 3'b001;
      #1;
      chk("c3_bc_go", 64'(bus3.inReady), 64'(1'b1));
      idle();
      tick();

      // randomised run against a per-channel queue scoreboard
      for (int c = 0; c < 420; c++) begin
         if (c < 400) begin
            bus.inValid     = ($urandom_range(0, 9) < 7);
            bus.inBroadcast = ($urandom_range(0, 99) < 15);
            bus.inSelect    = 2'($urandom_range(0, 3));
            bus.inData      = 8'($urandom);
            bus.outReady    = 4'($urandom) & 4'($urandom | $urandom);
         end else begin
            idle();
            bus.outReady = 4'b1111;
         end
         #1;
         eov = '0;
         for (int i = 0; i < 4; i++) begin
            eov[i] = (sb[i].size() != 0);
            fr[i]  = !eov[i] || bus.outReady[i];
         end
         if (bus.inBroadcast) erdy = &fr;
         else                 erdy = fr[bus.inSelect];
         chk("rnd_rdy", 64'(bus.inReady), 64'(erdy));
         chk("rnd_ov", 64'(bus.outValid), 64'(eov));
         for (int i = 0; i < 4; i++) begin
            if (eov[i] && bus.outReady[i]) begin
               chk($sformatf("rnd_data%0d", i),
                   64'(bus.outData[i*8 +: 8]), 64'(sb[i][0]));
               void'(sb[i].pop_front());
            end
         end
         if (bus.inValid && erdy) begin
            for (int i = 0; i < 4; i++)
               if (bus.inBroadcast || int'(bus.inSelect) == i)
                  sb[i].push_back(bus.inData);
         end
         tick();
      end
      for (int i = 0; i < 4; i++)
         chk("rnd_left", 64'(sb[i].size()), 64'(0));
      chk("rnd_end_ov", 64'(bus.outValid), 64'(4'b0000));
      chk("rnd_nodrop", 64'(bus.dropCount), 64'(8'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
